// File: rtl/ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the ram_arbiter slice: bus widths, FSM state
// encoding and requester port identifiers.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN
// -----------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_t;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

endpackage

// File: rtl/ram_arbiter_grant.sv
// -----------------------------------------------------------------------------
// arb_grant
// Pure combinational grant selector for the two requesters of ram_arbiter.
// A port is eligible when its req is high and its own ack is not high in the
// same cycle. No grant is offered while the driver still shows read_ready or
// write_finished from a previous access.
//
// Ports:
//   i_last_port   : port granted last (only with ARB_ROUND_ROBIN_EN)
//   i_if_req      : instruction-fetch request
//   i_mem_req     : data request
//   i_if_ack      : registered if ack (holdoff)
//   i_mem_ack     : registered mem ack (holdoff)
//   i_drv_busy    : driver still reporting read_ready / write_finished
//   o_grant_valid : a grant may be issued this cycle
//   o_grant_port  : PORT_IF or PORT_MEM
//
// Macro: ARB_ROUND_ROBIN_EN selects round-robin on conflict; otherwise mem
// always beats if.
// -----------------------------------------------------------------------------
module arb_grant
    import ram_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic i_last_port,
`endif
    input  logic i_if_req,
    input  logic i_mem_req,
    input  logic i_if_ack,
    input  logic i_mem_ack,
    input  logic i_drv_busy,
    output logic o_grant_valid,
    output logic o_grant_port
);

    logic w_if_ok;
    logic w_mem_ok;

    always_comb begin
        w_if_ok       = i_if_req && !i_if_ack;
        w_mem_ok      = i_mem_req && !i_mem_ack;
        o_grant_valid = !i_drv_busy && (w_if_ok || w_mem_ok);
`ifdef ARB_ROUND_ROBIN_EN
        // On conflict the port that did not win last time goes first.
        if (w_if_ok && w_mem_ok) begin
            o_grant_port = (i_last_port == PORT_MEM) ? PORT_IF : PORT_MEM;
        end else begin
            o_grant_port = w_mem_ok ? PORT_MEM : PORT_IF;
        end
`else
        o_grant_port = w_mem_ok ? PORT_MEM : PORT_IF;
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares one ram_driver SRAM port between the instruction-fetch port (if_*)
// and the data port (mem_*). One access at a time; address and write data are
// held on the driver for the whole access because the driver does not latch
// them. Every output is registered.
//
// Parameters:
//   RD_WAIT_CYCLES   : read_ready cycles before drv_data_out is captured (1..15)
//   RST_DRAIN_CYCLES : cycles after reset release before the first grant
//
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   if_req/if_addr/if_rdata/if_ack  : instruction read port
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : data port
//   drv_enable/drv_enable_read/drv_enable_write/drv_addr/drv_data_in : to driver
//   drv_data_out/drv_write_finished/drv_read_ready                  : from driver
//   busy                            : high in any state other than IDLE
//
// Macro: ARB_ROUND_ROBIN_EN adds a last-granted pointer for fair conflicts.
// -----------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_WAIT_CYCLES   = 1,
    parameter int RST_DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              drv_enable,
    output logic              drv_enable_read,
    output logic              drv_enable_write,
    output logic [ADDR_W-1:0] drv_addr,
    output logic [DATA_W-1:0] drv_data_in,
    input  logic [DATA_W-1:0] drv_data_out,
    input  logic              drv_write_finished,
    input  logic              drv_read_ready,
    output logic              busy
);

    localparam logic [3:0] RD_WAIT    = 4'(RD_WAIT_CYCLES);
    localparam logic [7:0] DRAIN_INIT = 8'(RST_DRAIN_CYCLES);

    state_t            r_state, w_next_state;
    logic [7:0]        r_drain_cnt, w_drain_cnt;
    logic [3:0]        r_wait_cnt, w_wait_cnt;
    logic              r_port, w_port;
    logic              r_enable, w_enable;
    logic              r_en_rd, w_en_rd;
    logic              r_en_wr, w_en_wr;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic              r_if_ack, w_if_ack;
    logic              r_mem_ack, w_mem_ack;
    logic [DATA_W-1:0] r_if_rdata, r_mem_rdata;
    logic              r_busy;
    logic              w_capture;
    logic              w_grant_valid;
    logic              w_grant_port;
    logic              w_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_port;
`endif

    arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .i_last_port   (r_last_port),
`endif
        .i_if_req      (if_req),
        .i_mem_req     (mem_req),
        .i_if_ack      (r_if_ack),
        .i_mem_ack     (r_mem_ack),
        .i_drv_busy    (drv_read_ready || drv_write_finished),
        .o_grant_valid (w_grant_valid),
        .o_grant_port  (w_grant_port)
    );

    assign w_grant = (r_state == ST_IDLE) && w_grant_valid;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        w_next_state = r_state;
        w_drain_cnt  = r_drain_cnt;
        w_wait_cnt   = r_wait_cnt;
        w_port       = r_port;
        w_enable     = r_enable;
        w_en_rd      = r_en_rd;
        w_en_wr      = 1'b0;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_if_ack     = 1'b0;
        w_mem_ack    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                if (r_drain_cnt != 8'd0) begin
                    w_drain_cnt = r_drain_cnt - 8'd1;
                end
                // Leave on the edge where the counter reaches zero.
                if (r_drain_cnt <= 8'd1 && !drv_read_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_grant) begin
                    w_enable = 1'b1;
                    w_port   = w_grant_port;
                    if (w_grant_port == PORT_MEM && mem_we) begin
                        w_en_wr      = 1'b1;
                        w_addr       = mem_addr;
                        w_wdata      = mem_wdata;
                        w_next_state = ST_WR;
                    end else begin
                        w_en_rd      = 1'b1;
                        w_addr       = (w_grant_port == PORT_MEM) ? mem_addr : if_addr;
                        w_wait_cnt   = 4'd0;
                        w_next_state = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (drv_read_ready) begin
                    w_wait_cnt = r_wait_cnt + 4'd1;
                    if (r_wait_cnt + 4'd1 == RD_WAIT) begin
                        w_capture    = 1'b1;
                        w_if_ack     = (r_port == PORT_IF);
                        w_mem_ack    = (r_port == PORT_MEM);
                        w_enable     = 1'b0;
                        w_en_rd      = 1'b0;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_WR: begin
                // enable_write already dropped by its default; enable, addr, data held.
                if (drv_write_finished) begin
                    w_mem_ack    = 1'b1;
                    w_enable     = 1'b0;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_INIT;
            r_wait_cnt  <= 4'd0;
            r_port      <= PORT_MEM;
            r_enable    <= 1'b0;
            r_en_rd     <= 1'b0;
            r_en_wr     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_busy      <= 1'b0;
            // NOTE: rdata registers are plain flops, so they are reset here and written only on their own capture.
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_cnt;
            r_wait_cnt  <= w_wait_cnt;
            r_port      <= w_port;
            r_enable    <= w_enable;
            r_en_rd     <= w_en_rd;
            r_en_wr     <= w_en_wr;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_if_ack    <= w_if_ack;
            r_mem_ack   <= w_mem_ack;
            r_busy      <= (w_next_state != ST_IDLE);
            if (w_capture && r_port == PORT_IF) begin
                r_if_rdata <= drv_data_out;
            end
            if (w_capture && r_port == PORT_MEM) begin
                r_mem_rdata <= drv_data_out;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_port <= PORT_MEM;
        end else if (w_grant) begin
            r_last_port <= w_grant_port;
        end
    end
`endif

    assign drv_enable       = r_enable;
    assign drv_enable_read  = r_en_rd;
    assign drv_enable_write = r_en_wr;
    assign drv_addr         = r_addr;
    assign drv_data_in      = r_wdata;
    assign if_ack           = r_if_ack;
    assign mem_ack          = r_mem_ack;
    assign if_rdata         = r_if_rdata;
    assign mem_rdata        = r_mem_rdata;
    assign busy             = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter. A small ram_driver model answers reads one
// cycle after enable_read (read_ready registered) and finishes a write three
// cycles after enable_write. A second instance runs with RD_WAIT_CYCLES=3.
// Cycle 0 is the cycle in which a request is first driven; outputs are sampled
// 1 ns after each rising edge. Honours ARB_ROUND_ROBIN_EN for conflict order.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;
    import ram_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [20:0] if_addr = '0, mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ack, mem_ack, busy;
    logic        drv_enable, drv_enable_read, drv_enable_write;
    logic [20:0] drv_addr;
    logic [31:0] drv_data_in, drv_data_out;
    logic        drv_write_finished, drv_read_ready;

    // Second instance (RD_WAIT_CYCLES = 3)
    logic        if_req_3 = 1'b0, mem_req_3 = 1'b0, mem_we_3 = 1'b0;
    logic [20:0] if_addr_3 = '0, mem_addr_3 = '0;
    logic [31:0] mem_wdata_3 = '0;
    logic [31:0] if_rdata_3, mem_rdata_3;
    logic        if_ack_3, mem_ack_3, busy_3;
    logic        drv_enable_3, drv_enable_read_3, drv_enable_write_3;
    logic [20:0] drv_addr_3;
    logic [31:0] drv_data_in_3, drv_data_out_3;
    logic        drv_write_finished_3, drv_read_ready_3;

    always #5 clk = ~clk;

    ram_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .drv_enable(drv_enable), .drv_enable_read(drv_enable_read),
        .drv_enable_write(drv_enable_write), .drv_addr(drv_addr), .drv_data_in(drv_data_in),
        .drv_data_out(drv_data_out), .drv_write_finished(drv_write_finished),
        .drv_read_ready(drv_read_ready), .busy(busy)
    );

    ram_arbiter #(.RD_WAIT_CYCLES(3), .RST_DRAIN_CYCLES(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_rdata(if_rdata_3), .if_ack(if_ack_3),
        .mem_req(mem_req_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .mem_ack(mem_ack_3),
        .drv_enable(drv_enable_3), .drv_enable_read(drv_enable_read_3),
        .drv_enable_write(drv_enable_write_3), .drv_addr(drv_addr_3), .drv_data_in(drv_data_in_3),
        .drv_data_out(drv_data_out_3), .drv_write_finished(drv_write_finished_3),
        .drv_read_ready(drv_read_ready_3), .busy(busy_3)
    );

    // ---------------- ram_driver model ----------------
    logic [31:0] sram [256];
    logic        m_read_ready = 1'b0;
    logic [1:0]  m_wr_stage = 2'd0;
    logic [20:0] m_last_waddr = '0;
    logic [31:0] m_last_wdata = '0;
    logic        m3_read_ready = 1'b0;

    function automatic logic [7:0] idx(input logic [20:0] a);
        return {a[20], a[6:0]};
    endfunction

    always @(posedge clk) begin
        m_read_ready <= drv_enable && drv_enable_read;
        case (m_wr_stage)
            2'd0:    if (drv_enable_write) m_wr_stage <= 2'd1;
            2'd3:    m_wr_stage <= 2'd0;
            default: m_wr_stage <= m_wr_stage + 2'd1;
        endcase
        if (m_wr_stage == 2'd2) begin
            m_last_waddr <= drv_addr;
            m_last_wdata <= drv_data_in;
        end
        m3_read_ready <= drv_enable_3 && drv_enable_read_3;
    end

    assign drv_read_ready       = m_read_ready;
    assign drv_write_finished   = (m_wr_stage == 2'd3);
    assign drv_data_out         = m_read_ready ? sram[idx(drv_addr)] : 32'h0;
    assign drv_read_ready_3     = m3_read_ready;
    assign drv_write_finished_3 = 1'b0;
    assign drv_data_out_3       = m3_read_ready ? sram[idx(drv_addr_3)] : 32'h0;

    // ---------------- bookkeeping ----------------
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   mem_ack_cnt = 0, if_ack_cnt = 0, ack3_cnt = 0;
    int   mem_ack_cyc = -1, if_ack_cyc = -1, ack3_cyc = -1;
    int   en_cyc = 0, en_rd_cyc = 0, en_wr_cyc = 0;
    logic hold_mem = 1'b0;
    logic last_port = PORT_MEM;

    task automatic reset_counts();
        cyc = 0;
        mem_ack_cnt = 0; if_ack_cnt = 0; ack3_cnt = 0;
        mem_ack_cyc = -1; if_ack_cyc = -1; ack3_cyc = -1;
        en_cyc = 0; en_rd_cyc = 0; en_wr_cyc = 0;
    endtask

    // Advance one cycle, sample, and let the requesters drop req on ack.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (drv_enable === 1'b1) en_cyc++;
        if (drv_enable_read === 1'b1) en_rd_cyc++;
        if (drv_enable_write === 1'b1) en_wr_cyc++;
        if (mem_ack === 1'b1) begin
            mem_ack_cnt++; mem_ack_cyc = cyc; last_port = PORT_MEM;
            if (!hold_mem) mem_req = 1'b0;
        end
        if (if_ack === 1'b1) begin
            if_ack_cnt++; if_ack_cyc = cyc; last_port = PORT_IF; if_req = 1'b0;
        end
        if (mem_ack_3 === 1'b1) begin
            ack3_cnt++; ack3_cyc = cyc; mem_req_3 = 1'b0;
        end
    endtask

    task automatic run_until_acks(input int n_mem, input int n_if, input int limit);
        while ((mem_ack_cnt < n_mem || if_ack_cnt < n_if) && cyc < limit) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({drv_enable, drv_enable_read, drv_enable_write, if_ack, mem_ack, busy} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {drv_enable, drv_enable_read, drv_enable_write, if_ack, mem_ack, busy});
        else n_pass++;
        n_checks++;
        if ({drv_addr, drv_data_in} !== 53'h0)
            $display("FAIL reset_drv_bus: addr %h data %h expected 0", drv_addr, drv_data_in);
        else n_pass++;
        n_checks++;
        if ({if_rdata, mem_rdata} !== 64'h0)
            $display("FAIL reset_rdata: if %h mem %h expected 0", if_rdata, mem_rdata);
        else n_pass++;
        rst_n = 1'b1;
        reset_counts();
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL drain_busy: got %b expected 1", busy);
        else n_pass++;
        step();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL drain_done: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_single_read();
        reset_counts();
        mem_we = 1'b0; mem_addr = 21'h000010; mem_req = 1'b1;
        step();
        n_checks++;
        if ({drv_enable, drv_enable_read, drv_enable_write, drv_addr} !== {3'b110, 21'h000010})
            $display("FAIL rd_grant: got %b/%h expected 110/000010",
                     {drv_enable, drv_enable_read, drv_enable_write}, drv_addr);
        else n_pass++;
        run_until_acks(1, 0, 20);
        n_checks++;
        if (mem_ack_cyc !== 3) $display("FAIL rd_ack_cycle: got %0d expected 3", mem_ack_cyc);
        else n_pass++;
        n_checks++;
        if (mem_rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", mem_rdata);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (en_rd_cyc !== 2) $display("FAIL rd_enable_len: got %0d expected 2", en_rd_cyc);
        else n_pass++;
        n_checks++;
        if (mem_ack_cnt !== 1) $display("FAIL rd_ack_count: got %0d expected 1", mem_ack_cnt);
        else n_pass++;
        n_checks++;
        if (if_rdata !== 32'h0) $display("FAIL rd_other_port: if_rdata %h expected 0", if_rdata);
        else n_pass++;
    endtask

    task automatic test_single_write();
        reset_counts();
        mem_we = 1'b1; mem_addr = 21'h100004; mem_wdata = 32'h12345678; mem_req = 1'b1;
        step();
        n_checks++;
        if ({drv_enable, drv_enable_read, drv_enable_write, drv_data_in} !== {3'b101, 32'h12345678})
            $display("FAIL wr_grant: got %b/%h expected 101/12345678",
                     {drv_enable, drv_enable_read, drv_enable_write}, drv_data_in);
        else n_pass++;
        run_until_acks(1, 0, 20);
        n_checks++;
        if (mem_ack_cyc !== 5) $display("FAIL wr_ack_cycle: got %0d expected 5", mem_ack_cyc);
        else n_pass++;
        n_checks++;
        if (en_wr_cyc !== 1) $display("FAIL wr_strobe_len: got %0d expected 1", en_wr_cyc);
        else n_pass++;
        n_checks++;
        if (en_cyc !== 4) $display("FAIL wr_enable_len: got %0d expected 4", en_cyc);
        else n_pass++;
        n_checks++;
        if ({m_last_waddr, m_last_wdata} !== {21'h100004, 32'h12345678})
            $display("FAIL wr_extram: got %h/%h expected 100004/12345678", m_last_waddr, m_last_wdata);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if ({drv_enable, drv_addr, drv_data_in} !== {1'b0, 21'h100004, 32'h12345678})
            $display("FAIL wr_idle_hold: got %b/%h/%h expected 0/100004/12345678",
                     drv_enable, drv_addr, drv_data_in);
        else n_pass++;
    endtask

    task automatic test_conflict();
        for (int pair = 0; pair < 2; pair++) begin
            logic exp_mem_first;
            exp_mem_first = RR_EN ? (last_port == PORT_IF) : 1'b1;
            reset_counts();
            mem_we = 1'b0; mem_addr = 21'h000020; if_addr = 21'h000030;
            mem_req = 1'b1; if_req = 1'b1;
            run_until_acks(1, 1, 40);
            n_checks++;
            if (mem_ack_cyc !== (exp_mem_first ? 3 : 7))
                $display("FAIL conflict%0d_mem_ack: got %0d expected %0d", pair, mem_ack_cyc,
                         exp_mem_first ? 3 : 7);
            else n_pass++;
            n_checks++;
            if (if_ack_cyc !== (exp_mem_first ? 7 : 3))
                $display("FAIL conflict%0d_if_ack: got %0d expected %0d", pair, if_ack_cyc,
                         exp_mem_first ? 7 : 3);
            else n_pass++;
            n_checks++;
            if ({mem_rdata, if_rdata} !== {32'h11112222, 32'h33334444})
                $display("FAIL conflict%0d_data: got %h/%h expected 11112222/33334444",
                         pair, mem_rdata, if_rdata);
            else n_pass++;
            repeat (3) step();
        end
    endtask

    task automatic test_ack_holdoff();
        reset_counts();
        hold_mem = 1'b1;
        mem_we = 1'b1; mem_addr = 21'h100008; mem_wdata = 32'hCAFEF00D; mem_req = 1'b1;
        run_until_acks(1, 0, 20);
        n_checks++;
        if (mem_ack_cnt !== 1) $display("FAIL holdoff_first_ack: got %0d expected 1", mem_ack_cnt);
        else n_pass++;
        step();  // req still high during the ack cycle
        n_checks++;
        if ({drv_enable, drv_enable_write, mem_ack} !== 3'b000)
            $display("FAIL holdoff_no_grant: got %b expected 000", {drv_enable, drv_enable_write, mem_ack});
        else n_pass++;
        mem_req = 1'b0;
        hold_mem = 1'b0;
        step();
        n_checks++;
        if ({drv_enable, busy} !== 2'b00)
            $display("FAIL holdoff_idle: got %b expected 00", {drv_enable, busy});
        else n_pass++;
        repeat (4) step();
    endtask

    task automatic test_reset_mid_write();
        reset_counts();
        mem_we = 1'b1; mem_addr = 21'h100010; mem_wdata = 32'h0BADF00D; mem_req = 1'b1;
        step();
        n_checks++;
        if (drv_enable_write !== 1'b1) $display("FAIL rmw_grant: got %b expected 1", drv_enable_write);
        else n_pass++;
        step();
        rst_n = 1'b0;
        mem_req = 1'b0;
        if_addr = 21'h000040; if_req = 1'b1;
        #1;
        n_checks++;
        if ({drv_enable, drv_enable_read, drv_enable_write, busy, mem_ack, drv_addr} !== 26'h0)
            $display("FAIL rmw_async_clear: got %b/%h expected 00000/000000",
                     {drv_enable, drv_enable_read, drv_enable_write, busy, mem_ack}, drv_addr);
        else n_pass++;
        step(); step();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (drv_enable !== 1'b0) $display("FAIL rmw_drain_%0d: drv_enable %b expected 0", i, drv_enable);
            else n_pass++;
        end
        step();
        n_checks++;
        if ({drv_enable, drv_enable_read, drv_addr} !== {2'b11, 21'h000040})
            $display("FAIL rmw_first_grant: got %b/%h expected 11/000040",
                     {drv_enable, drv_enable_read}, drv_addr);
        else n_pass++;
        run_until_acks(0, 1, cyc + 20);
        n_checks++;
        if ({if_ack_cnt == 1, if_rdata} !== {1'b1, 32'h5A5A0F0F})
            $display("FAIL rmw_if_read: acks %0d data %h expected 1/5a5a0f0f", if_ack_cnt, if_rdata);
        else n_pass++;
        repeat (3) step();
    endtask

    task automatic test_wait3();
        reset_counts();
        mem_addr_3 = 21'h000055; mem_req_3 = 1'b1;
        while (ack3_cnt < 1 && cyc < 30) step();
        n_checks++;
        if (ack3_cyc !== 5) $display("FAIL wait3_ack_cycle: got %0d expected 5", ack3_cyc);
        else n_pass++;
        n_checks++;
        if (mem_rdata_3 !== 32'hA5A5A5A5) $display("FAIL wait3_data: got %h expected a5a5a5a5", mem_rdata_3);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if ({ack3_cnt == 1, if_ack_3, busy_3} !== 3'b100)
            $display("FAIL wait3_quiet: acks %0d if_ack %b busy %b expected 1/0/0", ack3_cnt, if_ack_3, busy_3);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 32'h0;
        sram[idx(21'h000010)] = 32'hDEADBEEF;
        sram[idx(21'h000020)] = 32'h11112222;
        sram[idx(21'h000030)] = 32'h33334444;
        sram[idx(21'h000040)] = 32'h5A5A0F0F;
        sram[idx(21'h000055)] = 32'hA5A5A5A5;
        test_reset();
        test_single_read();
        test_single_write();
        test_conflict();
        test_ack_holdoff();
        test_reset_mid_write();
        test_wait3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single ram_driver SRAM port between the CPU instruction-fetch port (if_*) and the data/memory-stage port (mem_*).
Accepts one request at a time and sequences the driver's enable/enable_read/enable_write protocol. Holds address and write data stable for the whole access, because the driver does not latch them. Returns read data and a one-cycle ack to the winning requester. Sits between the CPU core and ram_driver.

Parameters:
RD_WAIT_CYCLES, 1, cycles read_ready must be high before drv_data_out is captured (SRAM access time); legal range 1..15
RST_DRAIN_CYCLES, 4, cycles after reset release before the first grant; covers an unresettable in-flight driver write

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  instruction read request; held until if_ack
if_addr  in  21  instruction word address; bit 20 selects extram
if_rdata  out  32  registered instruction read data
if_ack  out  1  one-cycle completion pulse
mem_req  in  1  data request; held until mem_ack
mem_we  in  1  1 = write, 0 = read
mem_addr  in  21  data word address
mem_wdata  in  32  write data
mem_rdata  out  32  registered data read result
mem_ack  out  1  one-cycle completion pulse
drv_enable  out  1  to ram_driver enable
drv_enable_read  out  1  to ram_driver enable_read
drv_enable_write  out  1  to ram_driver enable_write
drv_addr  out  21  to ram_driver addr
drv_data_in  out  32  to ram_driver data_in
drv_data_out  in  32  from ram_driver data_out
drv_write_finished  in  1  from ram_driver
drv_read_ready  in  1  from ram_driver
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state DRAIN, drain counter = RST_DRAIN_CYCLES, rdata registers 0, RR pointer = mem.
- All outputs are registered. No combinational path exists from any input to any output.
- States: DRAIN, IDLE, RD, WR.
- DRAIN: decrement the counter each cycle. Go to IDLE when it reaches 0 and drv_read_ready==0.
- IDLE grant conditions, evaluated at posedge:
  - drv_read_ready==0 and drv_write_finished==0.
  - A port is not eligible in the cycle its own ack is high (ack holdoff). The requester drops req in its ack cycle.
  - Default priority: mem beats if.
- Grant, read: drv_enable=1, drv_enable_read=1, drv_addr=addr; go to RD with the wait counter cleared.
- Grant, write: drv_enable=1, drv_enable_write=1 for exactly one cycle, drv_addr=mem_addr, drv_data_in=mem_wdata; go to WR.
- RD:
  - Count cycles with drv_read_ready==1. On the edge the count reaches RD_WAIT_CYCLES, capture drv_data_out into the granted port's rdata.
  - On that same edge: pulse that port's ack, clear drv_enable and drv_enable_read, go to IDLE.
  - Read ack appears RD_WAIT_CYCLES+2 cycles after the cycle req is first high, with the arbiter idle.
- WR:
  - drv_enable_write drops after its single cycle; drv_enable, drv_addr and drv_data_in are held.
  - On drv_write_finished==1: pulse mem_ack, clear drv_enable, go to IDLE.
  - Nominal write ack appears 5 cycles after mem_req.
- drv_addr and drv_data_in retain their last values when idle. Only the enables return to 0.
- Simultaneous if_req and mem_req: mem wins; if waits with no loss. Back-to-back mem requests can starve if.
- req dropped before ack: protocol violation, behaviour undefined. The arbiter still completes the access and pulses ack.
- Reset mid-access: enables clear immediately and the arbiter enters DRAIN. A driver write already in WRITE0/WRITE1 finishes during DRAIN; no grant is issued until it does.
- rdata registers are updated only on their own port's capture; they are never cleared after reset.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a 1-bit last-granted pointer. On conflict, the port not granted last wins; the pointer updates on every grant.
- Undefined: fixed mem > if priority; no pointer register.

Decomposition:
- Package ram_arb_pkg: state encoding localparams (DRAIN, IDLE, RD, WR), port-id constants (PORT_IF=0, PORT_MEM=1), address/data width constants (21, 32).
- Sub-module arb_grant: pure grant selector (two reqs, two holdoff acks, RR pointer, ready guard -> grant valid + port id). Contains the ifdef'd round-robin logic.

Test Plan:
- Single read: mem_req, mem_we=0, addr=0x000010; driver model returns 0xDEADBEEF -> mem_rdata=0xDEADBEEF, mem_ack pulses once 3 cycles after req (W=1), drv_enable_read high 2 cycles.
- Single write: mem_we=1, addr=0x100004, wdata=0x12345678 -> drv_enable_write high exactly 1 cycle, drv_enable held through write_finished, mem_ack 5 cycles after req, extram model holds 0x12345678.
- Conflict: if_req and mem_req (read) both high in cycle 0 -> mem served first; if_ack follows after the guard; with ARB_ROUND_ROBIN_EN a second simultaneous pair grants if first.
- Ack holdoff: requester keeps req high one extra cycle after ack -> no second access starts in the ack cycle.
- Reset mid-write: assert rst_n=0 one cycle after write grant -> outputs 0 immediately; after release, no grant for 4 cycles; a pending if_req then completes with correct data.
- RD_WAIT_CYCLES=3: read of 0xA5A5A5A5 -> capture after 3 read_ready cycles, ack 5 cycles after req.
